ula_controlador: RTL and testbench
==================================

Name: ula_controlador

Overview:
Sequencer that sits in front of the 6-bit ULA and drives its operand/mode/opcode inputs. It accepts a stream of instructions over a valid/ready handshake and holds the ULA inputs stable for a programmable settle time. It then captures valor_out, overflow and is_zero into an accumulator and flags, and reports completion. The accumulator feeds back as operand A, giving a single-accumulator datapath around the ULA.

Parameters:
LARGURA, 6, data width; must match the ULA.
LATENCIA, 1, cycles the ULA inputs are held before capture; legal range is 1 or more.
CONT_W, 8, width of the executed-operation counter.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
instr_valid  in  1  instruction present.
instr_ready  out  1  controller can accept an instruction.
instr_carga  in  1  1 = load instr_operando into the accumulator and bypass the ULA.
instr_modo  in  1  ULA mode (0 = arithmetic, 1 = logic).
instr_op  in  4  ULA opcode; legal values are 0..7.
instr_operando  in  LARGURA  operand B, or the load value.
ula_a  out  LARGURA  to ULA valor_a.
ula_b  out  LARGURA  to ULA valor_b.
ula_modo  out  1  to ULA modo.
ula_operacao  out  4  to ULA operacao.
ula_valor  in  LARGURA  from ULA valor_out.
ula_overflow  in  1  from ULA overflow.
ula_is_zero  in  1  from ULA is_zero.
acumulador  out  LARGURA  current accumulator value.
res_valid  out  1  one-cycle pulse when an instruction completes.
flag_overflow  out  1  overflow of the last executed ULA op.
overflow_sticky  out  1  OR of all overflows since the last load or reset.
flag_zero  out  1  is_zero of the last executed ULA op.
erro_op  out  1  one-cycle pulse, coincident with res_valid, on an illegal opcode.
cont_ops  out  CONT_W  count of executed ULA ops; wraps modulo 2^CONT_W.

Behaviour:
- Reset (async, while high): all outputs and registers are 0, state is OCIOSO, instr_ready = 0. An in-flight instruction is dropped with no res_valid.
- Every output is registered except instr_ready, which equals (state == OCIOSO) and not reset.
- States: OCIOSO, EXEC.
- OCIOSO, handshake: an instruction is accepted on a rising edge with instr_valid and instr_ready both high. instr_valid may be held high; instr_* fields are sampled only at the accept edge.
- OCIOSO, accept with instr_carga = 1:
  - acumulador <= instr_operando.
  - overflow_sticky <= 0.
  - res_valid pulses the next cycle; stay in OCIOSO.
  - ULA ports, cont_ops, flag_overflow and flag_zero are unchanged.
- OCIOSO, accept with instr_carga = 0 and instr_op[3] = 1:
  - res_valid and erro_op both pulse the next cycle; stay in OCIOSO.
  - Nothing else changes; the ULA is not driven.
- OCIOSO, accept with a legal opcode:
  - ula_a <= acumulador, ula_b <= instr_operando, ula_modo <= instr_modo, ula_operacao <= instr_op.
  - Counter cnt <= 0; go to EXEC.
- EXEC: ULA ports are held constant and cnt increments each edge. On the edge where cnt == LATENCIA-1:
  - acumulador <= ula_valor.
  - flag_overflow <= ula_overflow; overflow_sticky <= overflow_sticky | ula_overflow.
  - flag_zero <= ula_is_zero.
  - cont_ops <= cont_ops + 1.
  - res_valid <= 1; go to OCIOSO.
- Timing:
  - Accept at edge E0 means capture at edge E(LATENCIA), with res_valid and instr_ready both high in the cycle after it.
  - Throughput is one ULA op per LATENCIA+1 cycles; loads and illegal opcodes take 1 cycle each.
- ULA ports retain their last values while in OCIOSO.
- cont_ops wraps from 2^CONT_W-1 to 0 without any flag.
- Arithmetic: no width extension; all values are LARGURA bits, taken exactly as returned by the ULA.

Decomposition:
- Shared package ula_pkg holds:
  - the LARGURA default;
  - typedef for the opcode (4 bits) with named constants OP_SOMA .. OP_DEC_B (arithmetic) and OP_AND .. OP_RET_B (logic);
  - MODO_ARIT / MODO_LOGICO constants;
  - the state enum (OCIOSO, EXEC).
- No sub-module needed; the latency counter stays inline.

Test Plan:
1. Load: carga=1, operando=6'd5 -> acumulador=5 and one res_valid pulse next cycle; overflow_sticky=0, cont_ops=0.
2. Add: after test 1, send modo=0, op=0, operando=3 with a behavioural ULA model, LATENCIA=1 -> ula_a=5, ula_b=3, ula_modo=0, ula_operacao=0 for 1 cycle; then acumulador=8, flag_zero=0, cont_ops=1, res_valid pulse.
3. Illegal opcode: op=4'd9 -> res_valid and erro_op pulse together the next cycle; acumulador, cont_ops and ULA ports unchanged.
4. Sticky overflow: model forces ula_overflow=1 on one op, then 0 on the next -> flag_overflow goes 1 then 0, overflow_sticky stays 1 until a load with operando=0 clears it.
5. Back-to-back: LATENCIA=3, instr_valid held high, four logic ops (op=6, operando=1,2,3,4) -> one accept every 4 cycles; final acumulador equals the last ula_valor; cont_ops=4.
6. Reset mid-operation: assert reset in the 2nd EXEC cycle -> all outputs 0 immediately (asynchronous), no res_valid; instr_ready returns to 1 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ULA sequencer.
//   - LARGURA_PADRAO : default data width (must match the ULA)
//   - opcode_t       : 4-bit ULA opcode with named arithmetic/logic constants
//   - MODO_ARIT / MODO_LOGICO : ULA mode select values
//   - estado_t       : sequencer FSM states (OCIOSO, EXEC)
package ula_pkg;

  localparam int LARGURA_PADRAO = 6;

  typedef logic [3:0] opcode_t;

  // Arithmetic opcodes (modo = MODO_ARIT)
  localparam opcode_t OP_SOMA   = 4'd0;
  localparam opcode_t OP_SUB    = 4'd1;
  localparam opcode_t OP_SUB_BA = 4'd2;
  localparam opcode_t OP_NEG_A  = 4'd3;
  localparam opcode_t OP_INC_A  = 4'd4;
  localparam opcode_t OP_DEC_A  = 4'd5;
  localparam opcode_t OP_INC_B  = 4'd6;
  localparam opcode_t OP_DEC_B  = 4'd7;

  // Logic opcodes (modo = MODO_LOGICO)
  localparam opcode_t OP_AND    = 4'd0;
  localparam opcode_t OP_OR     = 4'd1;
  localparam opcode_t OP_NAND   = 4'd2;
  localparam opcode_t OP_NOR    = 4'd3;
  localparam opcode_t OP_NOT_A  = 4'd4;
  localparam opcode_t OP_RET_A  = 4'd5;
  localparam opcode_t OP_XOR    = 4'd6;
  localparam opcode_t OP_RET_B  = 4'd7;

  localparam logic MODO_ARIT   = 1'b0;
  localparam logic MODO_LOGICO = 1'b1;

  typedef enum logic {
    OCIOSO = 1'b0,
    EXEC   = 1'b1
  } estado_t;

  // Only opcodes 0..7 exist in the ULA; bit 3 set means illegal.
  function automatic logic op_ilegal(input opcode_t op);
    return op[3];
  endfunction

endpackage

// File: rtl/ula_controlador.sv
// ula_controlador: single-accumulator sequencer in front of the ULA.
//
// Accepts instructions over a valid/ready handshake, drives the ULA
// operand/mode/opcode inputs, holds them for LATENCIA cycles, then captures
// the ULA result and flags into the accumulator/flag registers.
//
// Handshake: an instruction transfers on a rising clock edge where
// instr_valid and instr_ready are both high. instr_ready is high only in
// OCIOSO and never during reset. instr_* fields are sampled only at that
// edge; instr_valid may stay high across several transfers.
//
// Ports:
//   clock, reset                      clock (rising edge), async active-high reset
//   instr_valid/instr_ready           instruction handshake
//   instr_carga                       1 = load instr_operando into accumulator
//   instr_modo, instr_op              ULA mode and opcode
//   instr_operando                    operand B or load value
//   ula_a, ula_b, ula_modo, ula_operacao  registered drive to the ULA
//   ula_valor, ula_overflow, ula_is_zero  results from the ULA
//   acumulador                        current accumulator
//   res_valid                         one-cycle completion pulse
//   flag_overflow, flag_zero          flags of the last executed ULA op
//   overflow_sticky                   OR of overflows since last load/reset
//   erro_op                           one-cycle pulse on illegal opcode
//   cont_ops                          executed ULA op count (wraps)
//   estado_dbg                        current FSM state, for observation
module ula_controlador
  import ula_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int LATENCIA = 1,
  parameter int CONT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               instr_carga,
  input  logic               instr_modo,
  input  logic [3:0]         instr_op,
  input  logic [LARGURA-1:0] instr_operando,
  output logic [LARGURA-1:0] ula_a,
  output logic [LARGURA-1:0] ula_b,
  output logic               ula_modo,
  output logic [3:0]         ula_operacao,
  input  logic [LARGURA-1:0] ula_valor,
  input  logic               ula_overflow,
  input  logic               ula_is_zero,
  output logic [LARGURA-1:0] acumulador,
  output logic               res_valid,
  output logic               flag_overflow,
  output logic               overflow_sticky,
  output logic               flag_zero,
  output logic               erro_op,
  output logic [CONT_W-1:0]  cont_ops,
  output logic               estado_dbg
);

  localparam int CNT_BITS = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LIM = CNT_BITS'(LATENCIA - 1);

  estado_t             state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [LARGURA-1:0]  ula_a_q, ula_a_d;
  logic [LARGURA-1:0]  ula_b_q, ula_b_d;
  logic                ula_modo_q, ula_modo_d;
  opcode_t             ula_op_q, ula_op_d;
  logic [LARGURA-1:0]  acc_q, acc_d;
  logic                res_valid_q, res_valid_d;
  logic                flag_ovf_q, flag_ovf_d;
  logic                sticky_q, sticky_d;
  logic                flag_zero_q, flag_zero_d;
  logic                erro_q, erro_d;
  logic [CONT_W-1:0]   cont_q, cont_d;
  logic                aceita;

  assign instr_ready = (state_q == OCIOSO) && !reset;
  assign aceita      = instr_valid && instr_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ula_a_d     = ula_a_q;
    ula_b_d     = ula_b_q;
    ula_modo_d  = ula_modo_q;
    ula_op_d    = ula_op_q;
    acc_d       = acc_q;
    res_valid_d = 1'b0;
    flag_ovf_d  = flag_ovf_q;
    sticky_d    = sticky_q;
    flag_zero_d = flag_zero_q;
    erro_d      = 1'b0;
    cont_d      = cont_q;

    case (state_q)
      OCIOSO: begin
        if (aceita) begin
          if (instr_carga) begin
            // Load bypasses the ULA and starts a fresh overflow history.
            acc_d       = instr_operando;
            sticky_d    = 1'b0;
            res_valid_d = 1'b1;
          end else if (op_ilegal(instr_op)) begin
            // Rejected without touching the ULA or any result state.
            res_valid_d = 1'b1;
            erro_d      = 1'b1;
          end else begin
            ula_a_d    = acc_q;
            ula_b_d    = instr_operando;
            ula_modo_d = instr_modo;
            ula_op_d   = instr_op;
            cnt_d      = '0;
            state_d    = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == CNT_LIM) begin
          acc_d       = ula_valor;
          flag_ovf_d  = ula_overflow;
          sticky_d    = sticky_q | ula_overflow;
          flag_zero_d = ula_is_zero;
          cont_d      = cont_q + CONT_W'(1);
          res_valid_d = 1'b1;
          state_d     = OCIOSO;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= OCIOSO;
      cnt_q       <= '0;
      ula_a_q     <= '0;
      ula_b_q     <= '0;
      ula_modo_q  <= 1'b0;
      ula_op_q    <= '0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      flag_ovf_q  <= 1'b0;
      sticky_q    <= 1'b0;
      flag_zero_q <= 1'b0;
      erro_q      <= 1'b0;
      cont_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ula_a_q     <= ula_a_d;
      ula_b_q     <= ula_b_d;
      ula_modo_q  <= ula_modo_d;
      ula_op_q    <= ula_op_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      flag_ovf_q  <= flag_ovf_d;
      sticky_q    <= sticky_d;
      flag_zero_q <= flag_zero_d;
      erro_q      <= erro_d;
      cont_q      <= cont_d;
    end
  end

  assign ula_a           = ula_a_q;
  assign ula_b           = ula_b_q;
  assign ula_modo        = ula_modo_q;
  assign ula_operacao    = ula_op_q;
  assign acumulador      = acc_q;
  assign res_valid       = res_valid_q;
  assign flag_overflow   = flag_ovf_q;
  assign overflow_sticky = sticky_q;
  assign flag_zero       = flag_zero_q;
  assign erro_op         = erro_q;
  assign cont_ops        = cont_q;
  assign estado_dbg      = state_q;

endmodule

// File: tb/tb_ula_controlador.sv
// Bench for ula_controlador: u1 with LATENCIA=1, u2 with LATENCIA=3, each
// wrapped by a behavioural ULA model. Directed scenarios with hand-computed
// expectations, one task per scenario.
module tb_ula_controlador;

  localparam int W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic force_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance 1 (LATENCIA = 1) ----------------
  logic         v1, rdy1, carga1, modo1, um1, uovf1, uz1, rv1, fov1, sov1, fz1, err1, st1;
  logic [3:0]   op1, uop1;
  logic [W-1:0] opnd1, a1, b1, uv1, acc1;
  logic [7:0]   cnt1;

  // ---------------- instance 2 (LATENCIA = 3) ----------------
  logic         v2, rdy2, carga2, modo2, um2, uovf2, uz2, rv2, fov2, sov2, fz2, err2, st2;
  logic [3:0]   op2, uop2;
  logic [W-1:0] opnd2, a2, b2, uv2, acc2;
  logic [7:0]   cnt2;

  ula_controlador #(.LARGURA(W), .LATENCIA(1), .CONT_W(8)) u1 (
    .clock(clk), .reset(reset),
    .instr_valid(v1), .instr_ready(rdy1), .instr_carga(carga1), .instr_modo(modo1),
    .instr_op(op1), .instr_operando(opnd1),
    .ula_a(a1), .ula_b(b1), .ula_modo(um1), .ula_operacao(uop1),
    .ula_valor(uv1), .ula_overflow(uovf1), .ula_is_zero(uz1),
    .acumulador(acc1), .res_valid(rv1), .flag_overflow(fov1), .overflow_sticky(sov1),
    .flag_zero(fz1), .erro_op(err1), .cont_ops(cnt1), .estado_dbg(st1)
  );

  ula_controlador #(.LARGURA(W), .LATENCIA(3), .CONT_W(8)) u2 (
    .clock(clk), .reset(reset),
    .instr_valid(v2), .instr_ready(rdy2), .instr_carga(carga2), .instr_modo(modo2),
    .instr_op(op2), .instr_operando(opnd2),
    .ula_a(a2), .ula_b(b2), .ula_modo(um2), .ula_operacao(uop2),
    .ula_valor(uv2), .ula_overflow(uovf2), .ula_is_zero(uz2),
    .acumulador(acc2), .res_valid(rv2), .flag_overflow(fov2), .overflow_sticky(sov2),
    .flag_zero(fz2), .erro_op(err2), .cont_ops(cnt2), .estado_dbg(st2)
  );

  // Behavioural ULA: returns {overflow, valor}. Only the ops the bench uses
  // need to be exact; others return a deterministic value.
  function automatic logic [W:0] ula_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic m, input logic [3:0] op);
    logic [W-1:0] r;
    logic         o;
    r = '0;
    o = 1'b0;
    if (!m) begin
      case (op)
        4'd0: begin r = a + b; o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
        4'd1: r = a - b;
        default: r = a;
      endcase
    end else begin
      case (op)
        4'd0: r = a & b;
        4'd1: r = a | b;
        4'd6: r = a ^ b;
        4'd7: r = b;
        default: r = a;
      endcase
    end
    return {o, r};
  endfunction

  always_comb begin
    logic [W:0] r1, r2;
    r1 = ula_ref(a1, b1, um1, uop1);
    r2 = ula_ref(a2, b2, um2, uop2);
    uv1   = r1[W-1:0];
    uovf1 = r1[W] | force_ovf;
    uz1   = (r1[W-1:0] == '0);
    uv2   = r2[W-1:0];
    uovf2 = r2[W];
    uz2   = (r2[W-1:0] == '0);
  end

  // ---------------- driver tasks ----------------
  // Present one instruction, let it transfer at the next rising edge, and
  // return at the falling edge that follows (first cycle after accept).
  task automatic send1(input logic c, input logic m, input logic [3:0] op, input logic [W-1:0] d);
    @(negedge clk);
    n_checks++;
    if (rdy1 !== 1'b1) begin
      $display("FAIL send1_ready: instr_ready=%b required 1", rdy1); n_fail++;
    end
    carga1 = c; modo1 = m; op1 = op; opnd1 = d; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic send2(input logic c, input logic m, input logic [3:0] op, input logic [W-1:0] d);
    @(negedge clk);
    n_checks++;
    if (rdy2 !== 1'b1) begin
      $display("FAIL send2_ready: instr_ready=%b required 1", rdy2); n_fail++;
    end
    carga2 = c; modo2 = m; op2 = op; opnd2 = d; v2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; force_ovf = 1'b0;
    v1 = 0; carga1 = 0; modo1 = 0; op1 = 0; opnd1 = 0;
    v2 = 0; carga2 = 0; modo2 = 0; op2 = 0; opnd2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin
      $display("FAIL reset_ready: rdy1=%b rdy2=%b required 0 0", rdy1, rdy2); n_fail++;
    end
    n_checks++;
    if ({acc1, a1, b1, um1, uop1, rv1, fov1, sov1, fz1, err1, cnt1, st1} !== '0) begin
      $display("FAIL reset_outputs: acc=%0d a=%0d b=%0d op=%0d rv=%b cnt=%0d required all 0",
               acc1, a1, b1, uop1, rv1, cnt1); n_fail++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (rdy1 !== 1'b1) begin
      $display("FAIL reset_release_ready: instr_ready=%b required 1", rdy1); n_fail++;
    end
  endtask

  task automatic test_load();
    send1(1'b1, 1'b0, 4'd0, 6'd5);
    n_checks++;
    if (rv1 !== 1'b1 || acc1 !== 6'd5 || sov1 !== 1'b0 || cnt1 !== 8'd0 || rdy1 !== 1'b1) begin
      $display("FAIL load: rv=%b acc=%0d sticky=%b cnt=%0d rdy=%b required 1 5 0 0 1",
               rv1, acc1, sov1, cnt1, rdy1); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (rv1 !== 1'b0) begin
      $display("FAIL load_pulse: res_valid=%b required 0", rv1); n_fail++;
    end
  endtask

  task automatic test_add();
    send1(1'b0, 1'b0, 4'd0, 6'd3);
    n_checks++;
    if (a1 !== 6'd5 || b1 !== 6'd3 || um1 !== 1'b0 || uop1 !== 4'd0 || rdy1 !== 1'b0 || rv1 !== 1'b0) begin
      $display("FAIL add_drive: a=%0d b=%0d modo=%b op=%0d rdy=%b rv=%b required 5 3 0 0 0 0",
               a1, b1, um1, uop1, rdy1, rv1); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (acc1 !== 6'd8 || rv1 !== 1'b1 || fz1 !== 1'b0 || fov1 !== 1'b0 || cnt1 !== 8'd1 || rdy1 !== 1'b1) begin
      $display("FAIL add_result: acc=%0d rv=%b zero=%b ovf=%b cnt=%0d rdy=%b required 8 1 0 0 1 1",
               acc1, rv1, fz1, fov1, cnt1, rdy1); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (rv1 !== 1'b0) begin
      $display("FAIL add_pulse: res_valid=%b required 0", rv1); n_fail++;
    end
  endtask

  task automatic test_illegal();
    send1(1'b0, 1'b1, 4'd9, 6'd17);
    n_checks++;
    if (rv1 !== 1'b1 || err1 !== 1'b1 || rdy1 !== 1'b1) begin
      $display("FAIL illegal_pulse: rv=%b erro=%b rdy=%b required 1 1 1", rv1, err1, rdy1); n_fail++;
    end
    n_checks++;
    if (acc1 !== 6'd8 || cnt1 !== 8'd1 || a1 !== 6'd5 || b1 !== 6'd3 || um1 !== 1'b0 || uop1 !== 4'd0) begin
      $display("FAIL illegal_hold: acc=%0d cnt=%0d a=%0d b=%0d modo=%b op=%0d required 8 1 5 3 0 0",
               acc1, cnt1, a1, b1, um1, uop1); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (rv1 !== 1'b0 || err1 !== 1'b0) begin
      $display("FAIL illegal_end: rv=%b erro=%b required 0 0", rv1, err1); n_fail++;
    end
  endtask

  task automatic test_sticky();
    force_ovf = 1'b1;
    send1(1'b0, 1'b0, 4'd0, 6'd1);
    @(negedge clk);
    n_checks++;
    if (acc1 !== 6'd9 || fov1 !== 1'b1 || sov1 !== 1'b1 || cnt1 !== 8'd2) begin
      $display("FAIL sticky_set: acc=%0d ovf=%b sticky=%b cnt=%0d required 9 1 1 2",
               acc1, fov1, sov1, cnt1); n_fail++;
    end
    force_ovf = 1'b0;
    send1(1'b0, 1'b0, 4'd0, 6'd1);
    n_checks++;
    if (a1 !== 6'd9) begin
      $display("FAIL sticky_feedback: ula_a=%0d required 9", a1); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (acc1 !== 6'd10 || fov1 !== 1'b0 || sov1 !== 1'b1 || cnt1 !== 8'd3) begin
      $display("FAIL sticky_hold: acc=%0d ovf=%b sticky=%b cnt=%0d required 10 0 1 3",
               acc1, fov1, sov1, cnt1); n_fail++;
    end
    send1(1'b1, 1'b0, 4'd0, 6'd0);
    n_checks++;
    if (acc1 !== 6'd0 || sov1 !== 1'b0 || fov1 !== 1'b0 || fz1 !== 1'b0 || cnt1 !== 8'd3 || rv1 !== 1'b1) begin
      $display("FAIL sticky_clear: acc=%0d sticky=%b ovf=%b zero=%b cnt=%0d rv=%b required 0 0 0 0 3 1",
               acc1, sov1, fov1, fz1, cnt1, rv1); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int           acc_cyc[4];
    int           k;
    logic [W-1:0] exp_acc;
    send2(1'b1, 1'b0, 4'd0, 6'd0);
    k = 0;
    exp_acc = '0;
    // instr_valid stays high; fields change only after each accept.
    for (int c = 0; c < 60 && k < 4; c++) begin
      if (rdy2) begin
        if (k > 0) begin
          n_checks++;
          if (acc2 !== exp_acc || rv2 !== 1'b1) begin
            $display("FAIL b2b_step%0d: acc=%0d rv=%b required %0d 1", k, acc2, rv2, exp_acc); n_fail++;
          end
        end
        carga2 = 1'b0; modo2 = 1'b1; op2 = 4'd6; opnd2 = 6'(k + 1); v2 = 1'b1;
        acc_cyc[k] = c;
        exp_acc = exp_acc ^ 6'(k + 1);
        k++;
      end
      @(negedge clk);
    end
    v2 = 1'b0;
    n_checks++;
    if (k != 4) begin
      $display("FAIL b2b_timeout: accepted=%0d required 4", k); n_fail++;
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
          $display("FAIL b2b_interval%0d: cycles=%0d required 4", i, acc_cyc[i] - acc_cyc[i-1]); n_fail++;
        end
      end
    end
    for (int t = 0; t < 10 && !rv2; t++) @(negedge clk);
    n_checks++;
    if (rv2 !== 1'b1 || acc2 !== 6'd4 || acc2 !== uv2 || cnt2 !== 8'd4 || fz2 !== 1'b0) begin
      $display("FAIL b2b_final: rv=%b acc=%0d ula_valor=%0d cnt=%0d zero=%b required 1 4 4 4 0",
               rv2, acc2, uv2, cnt2, fz2); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    logic seen_rv;
    send2(1'b0, 1'b1, 4'd0, 6'd7);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({acc2, a2, b2, um2, uop2, rv2, fov2, sov2, fz2, err2, cnt2, st2, rdy2} !== '0) begin
      $display("FAIL reset_mid_async: acc=%0d a=%0d b=%0d op=%0d cnt=%0d state=%b rdy=%b required all 0",
               acc2, a2, b2, uop2, cnt2, st2, rdy2); n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (rdy2 !== 1'b1) begin
      $display("FAIL reset_mid_ready: instr_ready=%b required 1", rdy2); n_fail++;
    end
    seen_rv = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (rv2 !== 1'b0) seen_rv = 1'b1;
    end
    n_checks++;
    if (seen_rv !== 1'b0 || acc2 !== 6'd0 || cnt2 !== 8'd0) begin
      $display("FAIL reset_mid_drop: res_valid_seen=%b acc=%0d cnt=%0d required 0 0 0",
               seen_rv, acc2, cnt2); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_illegal();
    test_sticky();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
